inv_key_stream: RTL and testbench
=================================

# inv_key_stream

Sequential AES-128 round-key generator for the decryptor. It accepts a cipher key, expands it forward one round per clock using the existing `KeyGeneration` round-step block, and stores all round keys in an internal register bank. It then streams them out over a valid/ready handshake, last round first, which is the order the inverse cipher consumes. The round count and the stream direction are parameters, so this block replaces fixed-depth combinational key chains in both the decryptor and the encryptor.

## Interface
Parameters:
- `NR`, default 10: number of expansion rounds, legal range 1..10. Round keys 0..NR are produced.
- `REVERSE`, default 1: 1 streams round NR down to 0 (decrypt order); 0 streams round 0 up to NR (encrypt order).
- `RW`, default 4: width of the round index, must satisfy `RW >= $clog2(NR+1)`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state and outputs.
- `start`  in  1  request a new expansion; sampled only in IDLE.
- `key_in`  in  128  cipher key (round key 0); sampled in the cycle `start` is accepted.
- `busy`  out  1  high in EXPAND and STREAM.
- `key_valid`  out  1  `key_out` and `key_round` are valid.
- `key_ready`  in  1  the consumer accepts the key; a transfer happens when `key_valid & key_ready`.
- `key_out`  out  128  current round key; 0 whenever `key_valid` is low.
- `key_round`  out  RW  round index of `key_out`; 0 whenever `key_valid` is low.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- Storage: a bank of NR+1 128-bit registers, slot r holds round key r. Nothing is reset except the control logic and outputs; slot contents are don't-care after reset.
- State machine: IDLE -> EXPAND -> STREAM -> DONE -> IDLE.
- IDLE:
  - With `start=1`: write `key_in` into slot 0, set the round counter to 1, go to EXPAND.
  - `start` in any other state is ignored and is not queued.
- EXPAND:
  - Each cycle, slot[cnt] <= KeyGeneration(rc = cnt-1, key = slot[cnt-1]).
  - Increment cnt.
  - After writing slot NR, go to STREAM and load the stream pointer (NR if REVERSE=1, else 0).
  - Exactly one `KeyGeneration` instance is shared by all rounds; rc is the 4-bit value cnt-1.
- STREAM:
  - `key_valid=1`, `key_out=slot[ptr]`, `key_round=ptr`. Both are registered outputs.
  - Hold all three stable while `key_ready=0`.
  - On a transfer, step ptr (decrement if REVERSE=1, increment otherwise).
  - A transfer on the last index (0 for REVERSE=1, NR for REVERSE=0) goes to DONE.
- DONE: `done=1` for one cycle, `busy=0`, `key_valid=0`, then IDLE. `start` is ignored in DONE.
- Reset mid-operation: returns to IDLE at once. `busy`, `key_valid` and `done` drop asynchronously, `key_out`/`key_round` go to 0, and any partial expansion is discarded.

## Timing
- Reset values: `busy=0`, `key_valid=0`, `done=0`, `key_out=0`, `key_round=0`, state IDLE.
- `start` accepted at edge T:
  - `busy=1` from T+1.
  - EXPAND covers cycles T+1..T+NR.
  - `key_valid=1` first at cycle T+NR+1.
- With `key_ready` held high: NR+1 transfers in consecutive cycles T+NR+1..T+2NR+1, `done` in cycle T+2NR+2, and the next `start` is accepted at edge T+2NR+3.
- Each cycle `key_ready` is low adds exactly one cycle to the stream.
- NR=1 boundary: one EXPAND cycle, two keys streamed.
- `key_ready` high outside STREAM has no effect.

## Test plan
- Decrypt order: NR=10, REVERSE=1, `key_in=2b7e151628aed2a6abf7158809cf4f3c`, `key_ready=1` -> first transfer at T+11 with round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`, round 1 = `a0fafe1788542cb123a339392a6c7605`, last transfer round 0 = `key_in`, `done` at T+22.
- Encrypt order: REVERSE=0, `key_in=000102030405060708090a0b0c0d0e0f` -> rounds stream 0..10 and round 10 = `13111d7fe3944a17f307a78b4d2b30c5`.
- Backpressure: drop `key_ready` for 3 cycles on round 7 -> `key_out`/`key_round` hold round 7, no skip or duplicate, and `done` arrives 3 cycles late.
- Busy/done start handling: pulse `start` with a different key during EXPAND, STREAM and DONE -> ignored, the original key stream is unchanged, and a second `start` in IDLE after `done` is accepted.
- Reset mid-stream: assert `rst` during the round 5 transfer -> all outputs 0 immediately; a new `start` gives a correct full stream.
- NR=6, REVERSE=1 -> first key equals round 6 of the FIPS-197 schedule (`6d88a37a110b3efddbf98641ca0093fd` for the `2b7e…` key), 7 transfers in total.

Source files
------------

// File: rtl/inv_key_stream.sv
// Sequential AES-128 key expansion into a register bank. Round keys are then
// streamed over valid/ready, last round first (REVERSE=1) or first round first.
module inv_key_stream #(
  parameter int unsigned NR      = 10,
  parameter bit          REVERSE = 1'b1,
  parameter int unsigned RW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key_in,
  output logic          busy,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [127:0]  key_out,
  output logic [RW-1:0] key_round,
  output logic          done
);

  localparam int unsigned KW = 128;
  localparam int unsigned NS = NR + 1;
  localparam logic [RW-1:0] FIRST_IDX = REVERSE ? RW'(NR) : RW'(0);
  localparam logic [RW-1:0] LAST_IDX  = REVERSE ? RW'(0) : RW'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_STREAM,
    S_DONE
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] r;
    case (rc)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // KeyGeneration round step: round key rc+1 from round key rc.
  function automatic logic [KW-1:0] key_generation(input logic [3:0] rc,
                                                   input logic [KW-1:0] key);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = key;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(rc), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ptr_q, ptr_d;
  logic [KW-1:0] slot_q [NS];
  logic [KW-1:0] slot_d [NS];
  logic          busy_q, busy_d;
  logic          key_valid_q, key_valid_d;
  logic [KW-1:0] key_out_q, key_out_d;
  logic [RW-1:0] key_round_q, key_round_d;
  logic          done_q, done_d;

  logic [KW-1:0] kg_src;
  logic [KW-1:0] kg_key;
  logic [3:0]    kg_rc;
  logic [RW-1:0] ptr_nxt;
  logic [KW-1:0] rd_key;

  // Single shared round step, fed from slot cnt-1.
  always_comb begin
    kg_src = slot_q[0];
    for (int unsigned i = 0; i < NR; i++) begin
      if (cnt_q == RW'(i + 1)) kg_src = slot_q[i];
    end
    kg_rc  = 4'(cnt_q - RW'(1));
    kg_key = key_generation(kg_rc, kg_src);
  end

  // Key presented after the next transfer.
  always_comb begin
    ptr_nxt = REVERSE ? (ptr_q - RW'(1)) : (ptr_q + RW'(1));
    rd_key  = slot_q[0];
    for (int unsigned i = 0; i < NS; i++) begin
      if (ptr_nxt == RW'(i)) rd_key = slot_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    slot_d      = slot_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    key_out_d   = key_out_q;
    key_round_d = key_round_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d      = 1'b0;
        key_valid_d = 1'b0;
        key_out_d   = '0;
        key_round_d = '0;
        if (start) begin
          slot_d[0] = key_in;
          cnt_d     = RW'(1);
          busy_d    = 1'b1;
          state_d   = S_EXPAND;
        end
      end

      S_EXPAND: begin
        for (int unsigned i = 1; i < NS; i++) begin
          if (cnt_q == RW'(i)) slot_d[i] = kg_key;
        end
        cnt_d = cnt_q + RW'(1);
        // The first reverse-order key is the one being written this cycle.
        if (cnt_q == RW'(NR)) begin
          state_d     = S_STREAM;
          ptr_d       = FIRST_IDX;
          key_valid_d = 1'b1;
          key_round_d = FIRST_IDX;
          key_out_d   = REVERSE ? kg_key : slot_q[0];
        end
      end

      S_STREAM: begin
        if (key_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            key_valid_d = 1'b0;
            key_out_d   = '0;
            key_round_d = '0;
            done_d      = 1'b1;
          end else begin
            ptr_d       = ptr_nxt;
            key_round_d = ptr_nxt;
            key_out_d   = rd_key;
          end
        end
      end

      S_DONE: begin
        busy_d      = 1'b0;
        key_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        key_valid_d = 1'b0;
        key_out_d   = '0;
        key_round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_out_q   <= '0;
      key_round_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      key_out_q   <= key_out_d;
      key_round_q <= key_round_d;
      done_q      <= done_d;
    end
  end

  // Round-key bank carries no reset; contents only matter after an expansion.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign busy      = busy_q;
  assign key_valid = key_valid_q;
  assign key_out   = key_out_q;
  assign key_round = key_round_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_stream.sv
// Scoreboard bench for inv_key_stream: four parameterisations share clock,
// reset, key and ready; a FIPS-197 key schedule model supplies expectations.
module tb_inv_key_stream;

  localparam int NI = 4;

  function automatic int nr_of(input int i);
    case (i)
      0: return 10;
      1: return 10;
      2: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic bit rev_of(input int i);
    return (i == 0 || i == 2);
  endfunction

  logic           clk = 1'b0;
  logic           rst;
  logic [NI-1:0]  start_v;
  logic [127:0]   key_in;
  logic           key_ready;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  int             go_seq = 0;
  int             go_t0 = 0;
  logic [NI-1:0]  go_mask = '0;
  logic [127:0]   go_key = '0;

  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Word-oriented key expansion, returning round key r.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 4 * (r + 1); i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int NRI  = nr_of(gi);
    localparam bit REVI = rev_of(gi);

    logic         busy, key_valid, done;
    logic [127:0] key_out;
    logic [3:0]   key_round;

    inv_key_stream #(.NR(NRI), .REVERSE(REVI), .RW(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[gi]),
      .key_in    (key_in),
      .busy      (busy),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_out   (key_out),
      .key_round (key_round),
      .done      (done)
    );

    logic [131:0] exp_q [$];
    logic [131:0] held = '0;
    logic [127:0] seen [11];
    int t0 = 0, last_seq = 0, stalls = 0, n_xfer = 0, done_cyc = 0;
    bit in_flight = 1'b0, pending = 1'b0, got_first = 1'b0, stall_prev = 1'b0;

    always @(negedge clk) begin : mon
      logic [131:0] e;
      if (rst) begin
        exp_q.delete();
        in_flight = 1'b0; pending = 1'b0; got_first = 1'b0; stall_prev = 1'b0;
        chk($sformatf("g%0d_rst_flags", gi), {129'd0, busy, key_valid, done}, 132'd0);
        chk($sformatf("g%0d_rst_data", gi), {key_round, key_out}, 132'd0);
      end else begin
        if (go_seq != last_seq) begin
          last_seq = go_seq;
          if (go_mask[gi]) begin
            t0 = go_t0;
            exp_q.delete();
            for (int k = 0; k <= NRI; k++) begin
              int r;
              r = REVI ? (NRI - k) : k;
              exp_q.push_back({4'(r), round_key(go_key, r)});
            end
            in_flight = 1'b1; pending = 1'b1; got_first = 1'b0;
            stall_prev = 1'b0; stalls = 0; n_xfer = 0;
          end
        end
        chk($sformatf("g%0d_busy", gi), {131'd0, busy}, {131'd0, in_flight});
        if (!key_valid) begin
          chk($sformatf("g%0d_idle_zero", gi), {key_round, key_out}, 132'd0);
          stall_prev = 1'b0;
        end else begin
          if (!got_first) begin
            got_first = 1'b1;
            chk($sformatf("g%0d_first_valid_cyc", gi), 132'(cyc), 132'(t0 + NRI));
          end
          if (stall_prev) chk($sformatf("g%0d_hold", gi), {key_round, key_out}, held);
          if (key_ready) begin
            stall_prev = 1'b0;
            if (exp_q.size() == 0) begin
              chk($sformatf("g%0d_unexpected_xfer", gi), {key_round, key_out}, 132'd0 - 132'd1);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("g%0d_xfer", gi), {key_round, key_out}, e);
              if (key_round <= 4'd10) seen[key_round] = key_out;
              n_xfer++;
              if (exp_q.size() == 0) in_flight = 1'b0;
            end
          end else begin
            stalls++;
            stall_prev = 1'b1;
            held = {key_round, key_out};
          end
        end
        if (done) begin
          chk($sformatf("g%0d_done_cyc", gi), 132'(cyc), 132'(t0 + 2 * NRI + 1 + stalls));
          chk($sformatf("g%0d_done_complete", gi),
              {131'd0, pending && exp_q.size() == 0}, 132'd1);
          pending = 1'b0;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic start_run(input logic [NI-1:0] m, input logic [127:0] k);
    @(negedge clk);
    key_in = k; start_v = m;
    @(posedge clk); #1;
    start_v = '0;
    go_t0 = cyc; go_key = k; go_mask = m;
    go_seq++;
    @(negedge clk); #1;
  endtask

  task automatic poke0();
    @(negedge clk);
    key_in = rand128(); start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  task automatic wait_all(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((g[0].pending || g[1].pending || g[2].pending || g[3].pending) && n < budget) begin
      @(posedge clk); #1;
      if (rnd) key_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (g[0].pending || g[1].pending || g[2].pending || g[3].pending) begin
      n_checks++;
      $display("FAIL wait_all_timeout: still pending after %0d cycles, expected all done", n);
    end
    key_ready = 1'b1;
  endtask

  initial begin
    logic [127:0] k;
    int n;
    rst = 1'b1; start_v = '0; key_in = '0; key_ready = 1'b1;
    build_sbox();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Known-answer runs, ready held high.
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start_run('1, k);
    wait_all(1'b0, 200);
    chk("kat_dec_r10", {4'd0, g[0].seen[10]}, {4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    chk("kat_dec_r1", {4'd0, g[0].seen[1]}, {4'd0, 128'ha0fafe1788542cb123a339392a6c7605});
    chk("kat_dec_r0", {4'd0, g[0].seen[0]}, {4'd0, k});
    chk("kat_dec_done_lat", 132'(g[0].done_cyc - g[0].t0), 132'd21);
    chk("kat_dec_count", 132'(g[0].n_xfer), 132'd11);
    chk("kat_nr6_r6", {4'd0, g[2].seen[6]}, {4'd0, 128'h6d88a37a110b3efddbf98641ca0093fd});
    chk("kat_nr6_count", 132'(g[2].n_xfer), 132'd7);
    chk("kat_nr1_count", 132'(g[3].n_xfer), 132'd2);

    start_run('1, 128'h000102030405060708090a0b0c0d0e0f);
    wait_all(1'b0, 200);
    chk("kat_enc_r10", {4'd0, g[1].seen[10]}, {4'd0, 128'h13111d7fe3944a17f307a78b4d2b30c5});
    chk("kat_enc_count", 132'(g[1].n_xfer), 132'd11);

    // Backpressure: three stalled cycles on round 7.
    start_run('1, k);
    n = 0;
    while (!(g[0].key_valid && g[0].key_round == 4'd7) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_ready = 1'b1;
    wait_all(1'b0, 200);
    chk("bp_done_lat", 132'(g[0].done_cyc - g[0].t0), 132'd24);
    chk("bp_count", 132'(g[0].n_xfer), 132'd11);

    // start pulses in EXPAND, STREAM and DONE must be ignored.
    start_run(4'b0001, rand128());
    poke0();
    n = 0;
    while (!g[0].key_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    poke0();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!g[0].done && n < 100);
    key_in = rand128(); start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    chk("start_in_done_ignored", {131'd0, g[0].busy}, 132'd0);
    wait_all(1'b0, 50);
    start_run(4'b0001, rand128());
    wait_all(1'b0, 200);
    chk("restart_count", 132'(g[0].n_xfer), 132'd11);

    // Asynchronous reset during the round 5 transfer.
    start_run('1, rand128());
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(g[0].key_valid && g[0].key_round == 4'd5) && n < 100);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {129'd0, g[0].busy, g[0].key_valid, g[0].done}, 132'd0);
    chk("async_rst_data", {g[0].key_round, g[0].key_out}, 132'd0);
    @(negedge clk); #1 rst = 1'b0;
    start_run('1, rand128());
    wait_all(1'b0, 200);
    chk("post_rst_count", 132'(g[0].n_xfer), 132'd11);

    // Random keys with random ready.
    for (int i = 0; i < 8; i++) begin
      start_run('1, rand128());
      wait_all(1'b1, 400);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
